clk_switch_ctrl: RTL and testbench

// - Safe driver of the select input of the glitch-free 2:1 clock mux. Runs on the always-on clk0_i.
// - Accepts clock-switch requests through a valid/ready handshake and checks that clk1_i is toggling before selecting it.
// - Holds off completion until the mux's two-stage synchronisers have settled, then reports done or error.

---
 rtl/clk_switch_ctrl.sv | 116 +++++++++++
 tb/tb_clk_switch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: safe select driver for a glitch-free 2:1 clock mux, with a clk1 activity monitor.
// Optional autonomous failover to clk0 when CLK_SWITCH_FAILSAFE_EN is defined.
module clk_switch_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int MON_WINDOW    = 64,
  parameter int MIN_EDGES     = 4
) (
  input  logic clk0_i,
  input  logic arst_ni,
  input  logic clk1_i,
  input  logic req_valid_i,
  input  logic req_sel_i,
  output logic req_ready_o,
  output logic sel_o,
  output logic cur_sel_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o,
  output logic clk1_alive_o,
  output logic mux_arst_no,
  output logic fail_o
);
  localparam int WW = $clog2(MON_WINDOW);
  localparam int EW = $clog2(MON_WINDOW + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
`ifdef CLK_SWITCH_FAILSAFE_EN
  typedef enum logic [2:0] {IDLE, CHECK, SWITCH, DONE, ERR, FAILOVER} state_t;
  logic mux_q, fail_q;
`else
  typedef enum logic [2:0] {IDLE, CHECK, SWITCH, DONE, ERR} state_t;
`endif
  state_t state, state_nx;
  logic t1, tgt, wrap, alive_nx, accept, fail_trig, settled;
  logic [2:0] sync;
  logic [WW-1:0] win;
  logic [EW-1:0] edges;
  logic [SW-1:0] cnt;
  always_ff @(posedge clk1_i or negedge arst_ni)
    if (!arst_ni) t1 <= 1'b0;
    else t1 <= ~t1;
  // sync[1:0] is the synchroniser, sync[2] the history flop for edge detection
  assign wrap     = win == WW'(MON_WINDOW - 1);
  assign alive_nx = edges >= EW'(MIN_EDGES);
  always_ff @(posedge clk0_i or negedge arst_ni)
    if (!arst_ni) begin
      sync         <= '0;
      win          <= '0;
      edges        <= '0;
      clk1_alive_o <= 1'b0;
    end else begin
      sync <= {sync[1:0], t1};
      win  <= wrap ? '0 : win + 1'b1;
      if (wrap) begin
        edges        <= '0;
        clk1_alive_o <= alive_nx;
      end else if ((sync[1] ^ sync[2]) && edges != '1) edges <= edges + 1'b1;
    end
`ifdef CLK_SWITCH_FAILSAFE_EN
  assign fail_trig   = state == IDLE && cur_sel_o && !clk1_alive_o;
  assign mux_arst_no = mux_q & arst_ni;
  assign fail_o      = fail_q;
`else
  assign fail_trig   = 1'b0;
  assign mux_arst_no = arst_ni;
  assign fail_o      = 1'b0;
`endif
  assign req_ready_o = state == IDLE && !fail_trig;
  assign accept      = req_valid_i && req_ready_o;
  assign busy_o      = state != IDLE;
  assign done_o      = state == DONE;
  assign err_o       = state == ERR;
  assign settled     = cnt == SW'(SETTLE_CYCLES - 1);
  always_comb begin
    state_nx = state;
    case (state)
`ifdef CLK_SWITCH_FAILSAFE_EN
      IDLE:     state_nx = fail_trig ? FAILOVER : !accept ? IDLE :
                           req_sel_i == cur_sel_o ? DONE : !req_sel_i ? SWITCH : CHECK;
      FAILOVER: state_nx = cnt == SW'(1) ? IDLE : FAILOVER;
`else
      IDLE:     state_nx = !accept ? IDLE : req_sel_i == cur_sel_o ? DONE : !req_sel_i ? SWITCH : CHECK;
`endif
      CHECK:    state_nx = !wrap ? CHECK : alive_nx ? SWITCH : ERR;
      SWITCH:   state_nx = settled ? DONE : SWITCH;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk0_i or negedge arst_ni)
    if (!arst_ni) begin
      state     <= IDLE;
      tgt       <= 1'b0;
      cnt       <= '0;
      sel_o     <= 1'b0;
      cur_sel_o <= 1'b0;
`ifdef CLK_SWITCH_FAILSAFE_EN
      mux_q     <= 1'b1;
      fail_q    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= state_nx != state ? '0 : cnt + 1'b1;
      if (accept) tgt <= req_sel_i;
      if (state_nx == SWITCH && state != SWITCH) sel_o <= state == IDLE ? req_sel_i : tgt;
      if (state == DONE) cur_sel_o <= sel_o;
`ifdef CLK_SWITCH_FAILSAFE_EN
      if (state_nx == FAILOVER && state != FAILOVER) begin
        sel_o     <= 1'b0;
        cur_sel_o <= 1'b0;
      end
      // a dead clk1 cannot complete the mux handshake, so reset the mux for the FAILOVER cycles
      mux_q <= state_nx != FAILOVER;
      if (state == FAILOVER && state_nx == IDLE) fail_q <= 1'b1;
      else if (accept) fail_q <= 1'b0;
`endif
    end
endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb_clk_switch_ctrl: scoreboard bench for clk_switch_ctrl (8/64/4, clk1 = clk0/3).
module tb_clk_switch_ctrl;
  logic clk0 = 0, clk1 = 0, arst_ni = 0, req_valid = 0, req_sel = 0, clk1_run = 1;
  logic req_ready, sel, cur_sel, busy, done, err, alive, mux_arst_n, fail;
  int cyc, checks, errors;
  typedef struct {logic is_err; int at;} exp_t;
  exp_t sb[$];

  clk_switch_ctrl #(.SETTLE_CYCLES(8), .MON_WINDOW(64), .MIN_EDGES(4)) dut (
    .clk0_i(clk0), .arst_ni(arst_ni), .clk1_i(clk1), .req_valid_i(req_valid), .req_sel_i(req_sel),
    .req_ready_o(req_ready), .sel_o(sel), .cur_sel_o(cur_sel), .busy_o(busy), .done_o(done),
    .err_o(err), .clk1_alive_o(alive), .mux_arst_no(mux_arst_n), .fail_o(fail)
  );

  always #5 clk0 = ~clk0;
  always #15 if (clk1_run) clk1 = ~clk1;
  always @(posedge clk0 or negedge arst_ni)
    if (!arst_ni) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic send(input logic s, output int n);
    @(negedge clk0);
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk0);
    req_valid = 1; req_sel = s; n = cyc + 1;
    @(negedge clk0);
    req_valid = 0;
  endtask

  task automatic wait_pulse(output bit ok);
    ok = done || err;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk0);
      ok = done || err;
    end
  endtask

  task automatic test_reset();
    arst_ni = 0; #1;
    checks++;
    if ({req_ready, sel, cur_sel, busy, done, err, alive, mux_arst_n, fail} !== 9'b100000000) begin
      errors++;
      $display("FAIL reset_vals: got %b want 100000000", {req_ready, sel, cur_sel, busy, done, err, alive, mux_arst_n, fail});
    end
    repeat (3) @(negedge clk0);
    arst_ni = 1;
    repeat (2) @(negedge clk0);
    checks++;
    if (mux_arst_n !== 1'b1 || req_ready !== 1'b1 || alive !== 1'b0) begin
      errors++; $display("FAIL post_release: mux_arst_n=%b ready=%b alive=%b want 1 1 0", mux_arst_n, req_ready, alive);
    end
    while (cyc < 66) @(negedge clk0);
    checks++;
    if (alive !== 1'b1) begin errors++; $display("FAIL first_window_alive: got %b want 1", alive); end
  endtask

  task automatic test_switch_to_clk1();
    int n, e_at, rise; bit ok, saw_err; exp_t x;
    send(1'b1, n);
    e_at = (n / 64 + 1) * 64;
    sb.push_back('{1'b0, e_at + 8});
    rise = -1; saw_err = 0;
    for (int i = 0; i < 200 && rise < 0; i++) begin
      if (err) saw_err = 1;
      if (sel) rise = cyc;
      else @(negedge clk0);
    end
    checks++;
    if (rise != e_at || saw_err) begin
      errors++; $display("FAIL sel_rise: got cycle %0d err=%0b want cycle %0d err=0", rise, saw_err, e_at);
    end
    wait_pulse(ok); x = sb.pop_front();
    checks++;
    if (!ok || done !== !x.is_err || err !== x.is_err || cyc != x.at) begin
      errors++; $display("FAIL switch1_resp: done=%b err=%b cycle %0d want err=%b cycle %0d", done, err, cyc, x.is_err, x.at);
    end
    @(negedge clk0);
    checks++;
    if (cur_sel !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL switch1_final: cur_sel=%b busy=%b ready=%b want 1 0 1", cur_sel, busy, req_ready);
    end
  endtask

  task automatic test_back_to_clk0();
    int n; bit ok, toggled; exp_t x;
    send(1'b0, n);
    sb.push_back('{1'b0, n + 8});
    req_valid = 1; req_sel = 1;
    checks++;
    if (sel !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL sel0_entry: sel=%b busy=%b ready=%b want 0 1 0", sel, busy, req_ready);
    end
    repeat (5) @(negedge clk0);
    req_valid = 0;
    wait_pulse(ok); x = sb.pop_front();
    checks++;
    if (!ok || done !== !x.is_err || err !== x.is_err || cyc != x.at) begin
      errors++; $display("FAIL sel0_resp: done=%b err=%b cycle %0d want err=%b cycle %0d", done, err, cyc, x.is_err, x.at);
    end
    toggled = 0;
    repeat (80) begin @(negedge clk0); if (sel) toggled = 1; end
    checks++;
    if (cur_sel !== 1'b0 || busy !== 1'b0 || toggled) begin
      errors++; $display("FAIL held_valid: cur_sel=%b busy=%b toggled=%0b want 0 0 0", cur_sel, busy, toggled);
    end
  endtask

  task automatic test_same_sel();
    int n; bit ok; exp_t x;
    send(1'b0, n);
    sb.push_back('{1'b0, n});
    wait_pulse(ok); x = sb.pop_front();
    checks++;
    if (!ok || done !== !x.is_err || err !== x.is_err || cyc != x.at || sel !== 1'b0) begin
      errors++; $display("FAIL same_resp: done=%b err=%b sel=%b cycle %0d want done cycle %0d sel 0", done, err, sel, cyc, x.at);
    end
    @(negedge clk0);
    checks++;
    if (sel !== 1'b0 || cur_sel !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL same_final: sel=%b cur_sel=%b busy=%b want 0 0 0", sel, cur_sel, busy);
    end
  endtask

  task automatic test_dead_clk1();
    int n, e_at; bit ok, bad; exp_t x;
    clk1_run = 0;
    repeat (140) @(negedge clk0);
    checks++;
    if (alive !== 1'b0) begin errors++; $display("FAIL dead_alive: got %b want 0", alive); end
    send(1'b1, n);
    e_at = (n / 64 + 1) * 64;
    sb.push_back('{1'b1, e_at});
    wait_pulse(ok); x = sb.pop_front();
    checks++;
    if (!ok || done !== !x.is_err || err !== x.is_err || cyc != x.at || sel !== 1'b0) begin
      errors++; $display("FAIL dead_resp: done=%b err=%b sel=%b cycle %0d want err cycle %0d sel 0", done, err, sel, cyc, x.at);
    end
    bad = 0;
    repeat (10) begin @(negedge clk0); if (done || sel) bad = 1; end
    checks++;
    if (bad || cur_sel !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL dead_after: done_or_sel=%0b cur_sel=%b busy=%b want 0 0 0", bad, cur_sel, busy);
    end
  endtask

  task automatic test_reset_mid_switch();
    int n, e_at; bit ok; exp_t x;
    clk1_run = 1;
    repeat (140) @(negedge clk0);
    send(1'b1, n);
    for (int i = 0; i < 200 && !sel; i++) @(negedge clk0);
    repeat (3) @(negedge clk0);
    checks++;
    if (sel !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL in_switch: sel=%b busy=%b want 1 1", sel, busy); end
    arst_ni = 0; #1;
    checks++;
    if ({req_ready, sel, cur_sel, busy, done, err, alive, mux_arst_n, fail} !== 9'b100000000) begin
      errors++;
      $display("FAIL mid_reset: got %b want 100000000", {req_ready, sel, cur_sel, busy, done, err, alive, mux_arst_n, fail});
    end
    sb.delete();
    repeat (3) @(negedge clk0);
    arst_ni = 1;
    send(1'b1, n);
    e_at = (n / 64 + 1) * 64;
    sb.push_back('{1'b0, e_at + 8});
    wait_pulse(ok); x = sb.pop_front();
    checks++;
    if (!ok || done !== !x.is_err || err !== x.is_err || cyc != x.at) begin
      errors++; $display("FAIL post_reset_resp: done=%b err=%b cycle %0d want done cycle %0d", done, err, cyc, x.at);
    end
    @(negedge clk0);
    checks++;
    if (cur_sel !== 1'b1 || sel !== 1'b1) begin errors++; $display("FAIL post_reset_sel: cur_sel=%b sel=%b want 1 1", cur_sel, sel); end
  endtask

  task automatic test_failover();
    int s, fell, lows;
    fell = -1; lows = 0;
    clk1_run = 0; s = cyc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk0);
      if (!mux_arst_n) lows++;
      if (fell < 0 && !sel) fell = cyc;
    end
`ifdef CLK_SWITCH_FAILSAFE_EN
    begin
      int n; bit ok; exp_t x;
      checks++;
      if (fell < 0 || fell > s + 130 || lows != 2 || fail !== 1'b1 || cur_sel !== 1'b0) begin
        errors++;
        $display("FAIL failover: fell=%0d (start %0d) mux_low=%0d fail=%b cur_sel=%b want <=%0d 2 1 0", fell, s, lows, fail, cur_sel, s + 130);
      end
      send(1'b0, n);
      sb.push_back('{1'b0, n});
      wait_pulse(ok); x = sb.pop_front();
      checks++;
      if (!ok || done !== !x.is_err || cyc != x.at || fail !== 1'b0) begin
        errors++; $display("FAIL fail_clear: done=%b cycle %0d fail=%b want done cycle %0d fail 0", done, cyc, fail, x.at);
      end
    end
`else
    checks++;
    if (fell >= 0 || lows != 0 || fail !== 1'b0 || cur_sel !== 1'b1) begin
      errors++;
      $display("FAIL no_failover: fell=%0d (start %0d) mux_low=%0d fail=%b cur_sel=%b want -1 0 0 1", fell, s, lows, fail, cur_sel);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_switch_to_clk1();
    test_back_to_clk0();
    test_same_sel();
    test_dead_clk1();
    test_reset_mid_switch();
    test_failover();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
